// File: rtl/dp_ram.sv
// ---------------------------------------------------------------------------
// dp_ram -- true dual-port, byte-writable 32-bit RAM with registered reads.
//
// Storage is four byte-lane arrays (ram0..ram3, lane n = data bits
// [8n+7:8n]), each 2**(SCALE-2) entries deep. Words are indexed by
// addr[SCALE-1:2]; the two low address bits are ignored.
//
// Parameters
//   SCALE   byte-address width (default 27)
//
// Ports
//   clk                 single clock, all state changes on its rising edge
//   rst                 asynchronous active-high reset (clears rdata only)
//   oe0 / oe1           port access enable
//   addr0 / addr1       byte address [SCALE-1:0]
//   wdata0 / wdata1     write data [31:0]
//   we0 / we1           byte write enables [3:0], bit n -> lane n
//   rdata0 / rdata1     registered read data [31:0], valid after the read edge
//
// Behaviour notes
//   - Read-first on both ports, including across ports: a read in the same
//     edge as a write to that word returns the old contents.
//   - When both ports write the same lane of the same word, port 0 wins.
//   - Reset clears rdata0/rdata1 and blocks reads/writes; array contents
//     are never touched by reset.
//
// Configuration macro
//   DP_RAM_INIT_ZERO_EN  when defined, every array entry starts at 8'h00;
//                        otherwise the arrays have no initialiser.
// ---------------------------------------------------------------------------
module dp_ram #(
    parameter int SCALE = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe0,
    input  logic [SCALE-1:0] addr0,
    input  logic [31:0]      wdata0,
    input  logic [3:0]       we0,
    output logic [31:0]      rdata0,
    input  logic             oe1,
    input  logic [SCALE-1:0] addr1,
    input  logic [31:0]      wdata1,
    input  logic [3:0]       we1,
    output logic [31:0]      rdata1
);

    localparam int AW    = SCALE - 2;
    localparam int DEPTH = 1 << AW;

    logic [7:0] ram0 [0:DEPTH-1];
    logic [7:0] ram1 [0:DEPTH-1];
    logic [7:0] ram2 [0:DEPTH-1];
    logic [7:0] ram3 [0:DEPTH-1];

    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic [31:0]   word0;
    logic [31:0]   word1;
    logic [31:0]   rdata0_d;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_d;
    logic [31:0]   rdata1_q;

    // Low address bits select a byte within the word and are deliberately
    // unused: there is no misaligned access support.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

    assign idx0 = addr0[SCALE-1:2];
    assign idx1 = addr1[SCALE-1:2];

    // Combinational view of the stored word before this edge's writes land,
    // which is what gives read-first behaviour on both ports.
    assign word0 = {ram3[idx0], ram2[idx0], ram1[idx0], ram0[idx0]};
    assign word1 = {ram3[idx1], ram2[idx1], ram1[idx1], ram0[idx1]};

    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (oe0) begin
            rdata0_d = word0;
        end
        if (oe1) begin
            rdata1_d = word1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    // Array writes. Port 1 is applied first so that a port-0 write to the
    // same lane on the same edge overrides it. Reset only gates the writes;
    // it never clears the arrays.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (oe1) begin
                if (we1[0]) ram0[idx1] <= wdata1[7:0];
                if (we1[1]) ram1[idx1] <= wdata1[15:8];
                if (we1[2]) ram2[idx1] <= wdata1[23:16];
                if (we1[3]) ram3[idx1] <= wdata1[31:24];
            end
            if (oe0) begin
                if (we0[0]) ram0[idx0] <= wdata0[7:0];
                if (we0[1]) ram1[idx0] <= wdata0[15:8];
                if (we0[2]) ram2[idx0] <= wdata0[23:16];
                if (we0[3]) ram3[idx0] <= wdata0[31:24];
            end
        end
    end

`ifdef DP_RAM_INIT_ZERO_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram0[i] = 8'h00;
            ram1[i] = 8'h00;
            ram2[i] = 8'h00;
            ram3[i] = 8'h00;
        end
    end
`else
    // No initialiser: entries never written or preloaded read as X.
`endif

endmodule

// File: tb/tb_dp_ram.sv
// ---------------------------------------------------------------------------
// tb_dp_ram -- scoreboard bench for dp_ram (SCALE = 8, 64 words).
// Stimulus pushes hand-computed expected read data into per-port queues;
// a monitor on the falling edge pops and compares whenever a read edge
// occurred, checks that rdata holds on idle edges and is zero in reset.
// ---------------------------------------------------------------------------
module tb_dp_ram;

    localparam int SCALE = 8;
    localparam int DEPTH = 1 << (SCALE - 2);

    logic             clk;
    logic             rst;
    logic             oe0, oe1;
    logic [SCALE-1:0] addr0, addr1;
    logic [31:0]      wdata0, wdata1;
    logic [3:0]       we0, we1;
    logic [31:0]      rdata0, rdata1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        rv0, rv1;
    logic [31:0] last0, last1;
    logic        last_ok;

    dp_ram #(.SCALE(SCALE)) dut (
        .clk(clk), .rst(rst),
        .oe0(oe0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .rdata0(rdata0),
        .oe1(oe1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .rdata1(rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Marks the edges on which each port actually performed a read.
    always @(posedge clk) begin
        rv0 <= oe0 && !rst;
        rv1 <= oe1 && !rst;
    end

    // Monitor: compare away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_rdata0", rdata0, 32'h0);
            chk("reset_rdata1", rdata1, 32'h0);
            last0   = 32'h0;
            last1   = 32'h0;
            last_ok = 1'b1;
        end else if (last_ok) begin
            if (rv0) begin
                if (q0.size() == 0) chk("p0_unexpected_read", 32'h1, 32'h0);
                else begin
                    last0 = q0.pop_front();
                    chk("p0_read", rdata0, last0);
                end
            end else chk("p0_hold", rdata0, last0);
            if (rv1) begin
                if (q1.size() == 0) chk("p1_unexpected_read", 32'h1, 32'h0);
                else begin
                    last1 = q1.pop_front();
                    chk("p1_read", rdata1, last1);
                end
            end else chk("p1_hold", rdata1, last1);
        end
    end

    // One clock of stimulus; e0/e1 are the expected read data for that edge.
    task automatic cyc(
        input logic o0, input logic [7:0] a0, input logic [31:0] d0,
        input logic [3:0] w0, input logic [31:0] e0,
        input logic o1, input logic [7:0] a1, input logic [31:0] d1,
        input logic [3:0] w1, input logic [31:0] e1);
        oe0 = o0; addr0 = a0; wdata0 = d0; we0 = w0;
        oe1 = o1; addr1 = a1; wdata1 = d1; we1 = w1;
        if (o0) q0.push_back(e0);
        if (o1) q1.push_back(e1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        last_ok = 1'b0;
        last0 = 32'h0; last1 = 32'h0;
        rst = 1'b0;
        oe0 = 1'b0; addr0 = '0; wdata0 = '0; we0 = '0;
        oe1 = 1'b0; addr1 = '0; wdata1 = '0; we1 = '0;
        #1 rst = 1'b1;
        // Preload word i = C0DE0000 + i through the lane arrays.
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'hC0DE_0000 + i;
            dut.ram0[i] = w[7:0];
            dut.ram1[i] = w[15:8];
            dut.ram2[i] = w[23:16];
            dut.ram3[i] = w[31:24];
        end
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        //   oe0 addr0  wdata0        we0      exp0            oe1 addr1  wdata1        we1      exp1
        cyc(1, 8'h10, 32'hDEADBEEF, 4'hF,    32'hC0DE0004,   1, 8'h24, 32'h0,        4'h0,    32'hC0DE0009);
        cyc(1, 8'h10, 32'h0,        4'h0,    32'hDEADBEEF,   0, 8'h00, 32'h0,        4'h0,    32'h0);
        cyc(1, 8'h10, 32'h11223344, 4'b0101, 32'hDEADBEEF,   0, 8'h00, 32'h0,        4'h0,    32'h0);
        cyc(1, 8'h10, 32'h0,        4'h0,    32'hDE22BE44,   0, 8'h00, 32'h0,        4'h0,    32'h0);
        cyc(1, 8'h10, 32'h0,        4'hF,    32'hDE22BE44,   0, 8'h00, 32'h0,        4'h0,    32'h0);
        cyc(1, 8'h10, 32'h0,        4'h0,    32'h00000000,   0, 8'h00, 32'h0,        4'h0,    32'h0);
        cyc(1, 8'h20, 32'hAAAA5555, 4'hF,    32'hC0DE0008,   1, 8'h24, 32'h0,        4'h0,    32'hC0DE0009);
        cyc(1, 8'h21, 32'h0,        4'h0,    32'hAAAA5555,   1, 8'h20, 32'h0,        4'h0,    32'hAAAA5555);
        cyc(1, 8'h23, 32'h0,        4'h0,    32'hAAAA5555,   1, 8'h22, 32'h0,        4'h0,    32'hAAAA5555);
        cyc(0, 8'h20, 32'hFFFFFFFF, 4'hF,    32'h0,          0, 8'h00, 32'h0,        4'h0,    32'h0);
        cyc(1, 8'h20, 32'h0,        4'h0,    32'hAAAA5555,   0, 8'h00, 32'h0,        4'h0,    32'h0);
        cyc(1, 8'h28, 32'h0,        4'h0,    32'hC0DE000A,   1, 8'h28, 32'h12345678, 4'hF,    32'hC0DE000A);
        cyc(1, 8'h28, 32'h0,        4'h0,    32'h12345678,   1, 8'h2C, 32'h0,        4'h0,    32'hC0DE000B);
        cyc(1, 8'h30, 32'h00000001, 4'hF,    32'hC0DE000C,   1, 8'h30, 32'h00000002, 4'hF,    32'hC0DE000C);
        cyc(0, 8'h00, 32'h0,        4'h0,    32'h0,          1, 8'h30, 32'h0,        4'h0,    32'h00000001);
        cyc(1, 8'h34, 32'hA1A2A3A4, 4'b0011, 32'hC0DE000D,   1, 8'h34, 32'hB1B2B3B4, 4'b0110, 32'hC0DE000D);
        cyc(1, 8'h34, 32'h0,        4'h0,    32'hC0B2A3A4,   1, 8'h34, 32'h0,        4'h0,    32'hC0B2A3A4);

        // Reset between edges while both ports try to write 0x3C.
        #2;
        rst = 1'b1;
        oe0 = 1'b1; addr0 = 8'h3C; wdata0 = 32'hFFFFFFFF; we0 = 4'hF;
        oe1 = 1'b1; addr1 = 8'h3C; wdata1 = 32'hEEEEEEEE; we1 = 4'hF;
        #1;
        chk("async_reset_rdata0", rdata0, 32'h0);
        chk("async_reset_rdata1", rdata1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        oe0 = 1'b0; we0 = 4'h0; oe1 = 1'b0; we1 = 4'h0;
        @(negedge clk);

        cyc(1, 8'h3C, 32'h0,        4'h0,    32'hC0DE000F,   1, 8'h34, 32'h0,        4'h0,    32'hC0B2A3A4);
        cyc(1, 8'h00, 32'h0,        4'h0,    32'hC0DE0000,   1, 8'hFC, 32'h0,        4'h0,    32'hC0DE003F);
        cyc(0, 8'h00, 32'h0,        4'h0,    32'h0,          0, 8'h00, 32'h0,        4'h0,    32'h0);
        @(negedge clk);
        @(negedge clk);

        chk("p0_queue_drained", q0.size(), 32'h0);
        chk("p1_queue_drained", q1.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
